spi_reg_ctrl: RTL and testbench

- Register-access controller on the sysclk side of the SPI slave byte engine.
- Synchronizes the engine's byte-ready strobe and chip-select into sysclk.
- Decodes a command/address/data byte protocol and maintains a 16-entry register map: fan PWM duty, tach status, ID and scratch.
- Supplies the response byte and its ready flag back to the engine for MISO.

---
 rtl/spi_reg_pkg.sv | 25 ++
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/spi_reg_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-access controller: register map
// addresses, command-byte layout and FSM state encoding.
package spi_reg_pkg;

  localparam logic [3:0] ADDR_DUTY0   = 4'h0;
  localparam logic [3:0] ADDR_DUTY1   = 4'h1;
  localparam logic [3:0] ADDR_DUTY2   = 4'h2;
  localparam logic [3:0] ADDR_DUTY3   = 4'h3;
  localparam logic [3:0] ADDR_TACH0   = 4'h4;
  localparam logic [3:0] ADDR_TACH1   = 4'h5;
  localparam logic [3:0] ADDR_TACH2   = 4'h6;
  localparam logic [3:0] ADDR_TACH3   = 4'h7;
  localparam logic [3:0] ADDR_ID      = 4'h8;
  localparam logic [3:0] ADDR_SCRATCH = 4'h9;

  localparam int CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer with a selectable asynchronous reset value.
module cdc_sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Sysclk-side register-access controller for the SPI slave byte engine:
// command/address/data decode, 16-entry register map and MISO response byte.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUTY_RESET  = 8'h80,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic        sysclk,
  input  logic        iReset,
  input  logic        iRxReady,
  input  logic [7:0]  iRx,
  input  logic        iSPICS,
  input  logic [31:0] iTach,
  output logic        oTxReady,
  output logic [7:0]  oTx,
  output logic [31:0] oDuty,
  output logic [3:0]  oDutyWr
);

  logic                   rx_sync_s;
  logic                   cs_sync_s;
  logic                   rx_pulse_s;
  logic                   settled_s;
  logic [3:0]             addr_inc_s;
  logic                   rx_prev_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   armed_q, armed_d;
  state_e                 state_q, state_d;
  logic [3:0]             addr_q, addr_d;
  logic [31:0]            duty_q, duty_d;
  logic [7:0]             scratch_q, scratch_d;
  logic [7:0]             tx_q, tx_d;
  logic                   tx_rdy_q, tx_rdy_d;
  logic [3:0]             duty_wr_q, duty_wr_d;

  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rx_sync (
    .clk_i (sysclk),
    .rst_i (iReset),
    .d_i   (iRxReady),
    .q_o   (rx_sync_s)
  );

  cdc_sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i (sysclk),
    .rst_i (iReset),
    .d_i   (iSPICS),
    .q_o   (cs_sync_s)
  );

  function automatic logic [7:0] reg_read(input logic [3:0]  a,
                                          input logic [31:0] duty,
                                          input logic [31:0] tach,
                                          input logic [7:0]  scratch);
    logic [7:0] v;
    case (a)
      ADDR_DUTY0:   v = duty[7:0];
      ADDR_DUTY1:   v = duty[15:8];
      ADDR_DUTY2:   v = duty[23:16];
      ADDR_DUTY3:   v = duty[31:24];
      ADDR_TACH0:   v = tach[7:0];
      ADDR_TACH1:   v = tach[15:8];
      ADDR_TACH2:   v = tach[23:16];
      ADDR_TACH3:   v = tach[31:24];
      ADDR_ID:      v = ID_VALUE;
      ADDR_SCRATCH: v = scratch;
      default:      v = 8'h00;
    endcase
    return v;
  endfunction

  assign rx_pulse_s = rx_sync_s & ~rx_prev_q;
  assign settled_s  = settle_q[SYNC_STAGES-1];
  assign addr_inc_s = addr_q + 4'd1;

  // Next-state, register-map update and response-byte selection.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    duty_d    = duty_q;
    scratch_d = scratch_q;
    tx_d      = tx_q;
    tx_rdy_d  = tx_rdy_q;
    duty_wr_d = 4'b0000;
    armed_d   = armed_q;

    // A new command is only accepted after CS has been genuinely seen high,
    // so a reset with CS held low does not restart a half-done transaction.
    if (cs_sync_s && settled_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      IDLE: begin
        if (!cs_sync_s && armed_q) begin
          state_d = CMD;
          armed_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (rx_pulse_s) begin
          addr_d = iRx[3:0];
          if (iRx[CMD_WR_BIT]) begin
            state_d = WR;
          end else begin
            state_d  = RD;
            tx_d     = reg_read(iRx[3:0], duty_q, iTach, scratch_q);
            tx_rdy_d = 1'b1;
          end
        end else begin
          state_d = CMD;
        end
      end
      WR: begin
        if (rx_pulse_s) begin
          if (addr_q[3:2] == 2'b00) begin
            duty_d[{addr_q[1:0], 3'b000} +: 8] = iRx;
            duty_wr_d[addr_q[1:0]]             = 1'b1;
          end else if (addr_q == ADDR_SCRATCH) begin
            scratch_d = iRx;
          end else begin
            scratch_d = scratch_q;
          end
          addr_d = addr_inc_s;
        end else begin
          addr_d = addr_q;
        end
      end
      RD: begin
        if (rx_pulse_s) begin
          addr_d = addr_inc_s;
          tx_d   = reg_read(addr_inc_s, duty_q, iTach, scratch_q);
        end else begin
          addr_d = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Deselect wins after any byte in the same cycle has been processed.
    if (cs_sync_s && (state_q != IDLE)) begin
      state_d  = IDLE;
      tx_rdy_d = 1'b0;
      addr_d   = 4'h0;
    end else begin
      tx_rdy_d = tx_rdy_d;
    end
  end

  // Strobe edge detect and synchronizer-settle tracking.
  always_ff @(posedge sysclk or posedge iReset) begin
    if (iReset) begin
      rx_prev_q <= 1'b0;
      settle_q  <= {SYNC_STAGES{1'b0}};
    end else begin
      rx_prev_q <= rx_sync_s;
      settle_q  <= {settle_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Controller state and register map.
  always_ff @(posedge sysclk or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      addr_q    <= 4'h0;
      duty_q    <= {4{DUTY_RESET}};
      scratch_q <= 8'h00;
      tx_q      <= 8'h00;
      tx_rdy_q  <= 1'b0;
      duty_wr_q <= 4'b0000;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      duty_q    <= duty_d;
      scratch_q <= scratch_d;
      tx_q      <= tx_d;
      tx_rdy_q  <= tx_rdy_d;
      duty_wr_q <= duty_wr_d;
      armed_q   <= armed_d;
    end
  end

  assign oTxReady = tx_rdy_q;
  assign oTx      = tx_q;
  assign oDuty    = duty_q;
  assign oDutyWr  = duty_wr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: a behavioural register-map model feeds
// an expectation queue that is popped once each byte has been processed.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  logic        sysclk = 1'b0;
  logic        iReset;
  logic        iRxReady;
  logic [7:0]  iRx;
  logic        iSPICS;
  logic [31:0] iTach;
  logic        oTxReady;
  logic [7:0]  oTx;
  logic [31:0] oDuty;
  logic [3:0]  oDutyWr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] tx;
    logic       rdy;
    logic [3:0] wr;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] m_duty [4];
  logic [7:0] m_scratch;
  logic [7:0] m_tx;
  logic       m_rdy;
  logic [3:0] m_addr;
  int         m_phase;

  always #5 sysclk = ~sysclk;

  spi_reg_ctrl #(.SYNC_STAGES(2), .DUTY_RESET(8'h80), .ID_VALUE(8'hA5)) dut (
    .sysclk   (sysclk),
    .iReset   (iReset),
    .iRxReady (iRxReady),
    .iRx      (iRx),
    .iSPICS   (iSPICS),
    .iTach    (iTach),
    .oTxReady (oTxReady),
    .oTx      (oTx),
    .oDuty    (oDuty),
    .oDutyWr  (oDutyWr)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] m_duty_word();
    return {m_duty[3], m_duty[2], m_duty[1], m_duty[0]};
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a < 4'h4)       return m_duty[a[1:0]];
    else if (a < 4'h8)  return iTach[{a[1:0], 3'b000} +: 8];
    else if (a == 4'h8) return 8'hA5;
    else if (a == 4'h9) return m_scratch;
    else                return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_duty[i] = 8'h80;
    m_scratch = 8'h00;
    m_tx      = 8'h00;
    m_rdy     = 1'b0;
    m_addr    = 4'h0;
    m_phase   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic cs_rise);
    exp_t       e;
    logic [3:0] wr;
    wr = 4'b0000;
    case (m_phase)
      1: begin
        m_addr = b[3:0];
        if (b[7]) begin
          m_phase = 2;
        end else begin
          m_phase = 3;
          m_tx    = m_read(m_addr);
          m_rdy   = 1'b1;
        end
      end
      2: begin
        if (m_addr < 4'h4) begin
          m_duty[m_addr[1:0]] = b;
          wr[m_addr[1:0]]     = 1'b1;
        end else if (m_addr == 4'h9) begin
          m_scratch = b;
        end
        m_addr = m_addr + 4'd1;
      end
      3: begin
        m_addr = m_addr + 4'd1;
        m_tx   = m_read(m_addr);
      end
      default: ;
    endcase
    if (cs_rise) begin
      m_rdy   = 1'b0;
      m_addr  = 4'h0;
      m_phase = 0;
    end
    e = '{tx: m_tx, rdy: m_rdy, wr: wr};
    exp_q.push_back(e);

    @(negedge sysclk);
    iRx      = b;
    iRxReady = 1'b1;
    if (cs_rise) iSPICS = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    e = exp_q.pop_front();
    check_eq("tx", {24'd0, oTx}, {24'd0, e.tx});
    check_eq("tx_ready", {31'd0, oTxReady}, {31'd0, e.rdy});
    check_eq("duty_wr", {28'd0, oDutyWr}, {28'd0, e.wr});
    check_eq("duty", oDuty, m_duty_word());
    @(posedge sysclk);
    #1;
    check_eq("duty_wr_end", {28'd0, oDutyWr}, 32'd0);
    @(negedge sysclk);
    iRxReady = 1'b0;
    repeat (3) @(posedge sysclk);
  endtask

  task automatic cs_low();
    @(negedge sysclk);
    iSPICS = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    m_phase = 1;
    m_addr  = 4'h0;
  endtask

  task automatic cs_high();
    @(negedge sysclk);
    iSPICS = 1'b1;
    repeat (4) @(posedge sysclk);
    #1;
    m_rdy   = 1'b0;
    m_phase = 0;
    m_addr  = 4'h0;
    check_eq("ready_after_cs", {31'd0, oTxReady}, 32'd0);
    check_eq("tx_hold", {24'd0, oTx}, {24'd0, m_tx});
  endtask

  initial begin
    iReset   = 1'b1;
    iRxReady = 1'b0;
    iSPICS   = 1'b1;
    iRx      = 8'h00;
    iTach    = 32'h0000_0000;
    model_reset();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    iReset = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
    check_eq("rst_duty", oDuty, 32'h8080_8080);
    check_eq("rst_tx", {24'd0, oTx}, 32'd0);
    check_eq("rst_ready", {31'd0, oTxReady}, 32'd0);
    check_eq("rst_duty_wr", {28'd0, oDutyWr}, 32'd0);

    // Read duty 0 straight after reset.
    cs_low(); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); cs_high();

    // Burst write of duty 1..3.
    cs_low();
    send_byte(8'h81, 1'b0); send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    cs_high();

    // Read-only ID and tach.
    cs_low(); send_byte(8'h88, 1'b0); send_byte(8'h55, 1'b0); cs_high();
    cs_low(); send_byte(8'h08, 1'b0); cs_high();
    iTach = 32'h0403_0201;
    cs_low(); send_byte(8'h84, 1'b0); send_byte(8'h55, 1'b0); cs_high();
    cs_low(); send_byte(8'h04, 1'b0); cs_high();

    // Read auto-increment wrapping 0xF -> 0x0, then tach/ID/scratch run.
    iTach = 32'hDDCC_BBAA;
    cs_low();
    send_byte(8'h0F, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
    cs_high();
    cs_low();
    send_byte(8'h06, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    cs_high();

    // Final write byte coincident with CS deselect.
    cs_low();
    send_byte(8'h89, 1'b0);
    send_byte(8'h5A, 1'b1);
    check_eq("state_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
    cs_low(); send_byte(8'h09, 1'b0); cs_high();

    // Reset in the middle of a write with CS held low.
    cs_low();
    send_byte(8'h80, 1'b0);
    @(negedge sysclk);
    iReset = 1'b1;
    @(negedge sysclk);
    iReset = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_duty", oDuty, 32'h8080_8080);
    repeat (4) @(posedge sysclk);
    send_byte(8'h33, 1'b0);
    cs_high();
    cs_low(); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); cs_high();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
